iterative_muldiv: RTL and testbench
===================================

ITERATIVE_MULDIV -- requirements
Module: iterative_muldiv

Interface
REQ-001 Parameter L, default 16, operand/result/flag width; SHALL be >= 8.
REQ-002 Clk  input  1  sole clock, rising edge.
REQ-003 ResetN  input  1  reset, asynchronous, active-low.
REQ-004 Operation  input  2  0 signed div, 1 signed mul, 2 unsigned div, 3 unsigned mul.
REQ-005 A, B  input  L  operands (dividend/divisor for div).
REQ-006 FlagsIn  input  L  current flag word.
REQ-007 InValid / InReady  input / output  1  request handshake.
REQ-008 OutValid / OutReady  output / input  1  result handshake.
REQ-009 Flush  input  1  synchronous abort.
REQ-010 R  output  L  quotient, or low half of product.
REQ-011 R2  output  L  remainder, or high half of 2L-bit product.
REQ-012 FlagsOut  output  L  updated flag word.

Function
REQ-013 FSM states IDLE, RUN, DONE; InReady=1 only in IDLE; OutValid=1 only in DONE.
REQ-014 Accept on edge with InValid&&InReady: latch Operation, |A|, |B| (raw for unsigned ops), result sign, FlagsIn; counter <- L; go RUN.
REQ-015 RUN: one bit per cycle (shift-add multiply, restoring divide); after L cycles go DONE; OutValid rises exactly L+1 cycles after the accepting edge.
REQ-016 Divide with B==0: go DONE directly; OutValid 1 cycle after accept; R=0, R2=A, DivisionByZero=1, DivisionHasRemainder=0.
REQ-017 Signed results: quotient/product sign = A[L-1]^B[L-1]; remainder sign = dividend sign; negative zero yields 0.
REQ-018 Signed div -2^(L-1) / -1: R wraps to -2^(L-1), R2=0, no flag set.
REQ-019 DivisionHasRemainder = remainder != 0; DivisionByZero = divisor == 0 (divide ops only).
REQ-020 MultiplicationOverflow: unsigned = high half != 0; signed = 2L-bit product not representable in L signed bits.
REQ-021 Divide ops pass latched MultiplicationOverflow through; multiply ops pass latched division flags through; bits [L-1:ZeroIdx] always pass latched FlagsIn through.
REQ-022 R, R2, FlagsOut registered, stable for the whole DONE state.
REQ-023 DONE holds until OutReady=1, then IDLE next cycle; no new request accepted in that same cycle.
REQ-024 Flush=1 in any state: IDLE next edge, OutValid=0, result discarded; Flush overrides simultaneous InValid.
REQ-025 R, R2 and FlagsOut SHALL not change outside the DONE-entry edge.

Reset
REQ-026 ResetN=0 asynchronously forces IDLE, counter 0, R=0, R2=0, FlagsOut=0, OutValid=0; InReady=1 after release.
REQ-027 Reset mid-RUN or mid-DONE discards the operation; no OutValid pulse after release.

Structure
REQ-028 Shared package holds flag index constants (DivisionHasRemainderIdx=0, DivisionByZeroIdx=1, MultiplicationOverflowIdx=2, ZeroIdx=3), Operation encodings and FSM state encoding.
REQ-029 Counter width $clog2(L+1).
REQ-030 One sub-module, muldiv_step: combinational single iteration (add/shift or trial-subtract) on accumulator, operand and partial result.

Verification (L=16)
REQ-031 Op1, A=7, B=0xFFFD -> OutValid at accept+17, R=0xFFEB, R2=0xFFFF, overflow 0.
REQ-032 Op0, A=0xFFF9, B=2 -> R=0xFFFD, R2=0xFFFF, HasRemainder=1, DivByZero=0.
REQ-033 Op0, A=5, B=0 -> OutValid at accept+1, R=0, R2=5, DivByZero=1.
REQ-034 Op3, A=B=0x0100, FlagsIn=0xFFF8 -> R=0, R2=0x0001, FlagsOut=0xFFFC.
REQ-035 OutReady low 5 cycles in DONE -> outputs constant, InReady=0; OutReady high -> IDLE next cycle.
REQ-036 Flush at RUN cycle 4, then new request; ResetN low at RUN cycle 8 -> no stale OutValid, all outputs 0, InReady=1 after release.

Source files
------------

// File: rtl/iterative_muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: flag bit positions,
// operation encodings and FSM state encodings.
package iterative_muldiv_pkg;

  localparam int DivisionHasRemainderIdx   = 0;
  localparam int DivisionByZeroIdx         = 1;
  localparam int MultiplicationOverflowIdx = 2;
  localparam int ZeroIdx                   = 3;

  localparam logic [1:0] OpSignedDiv   = 2'd0;
  localparam logic [1:0] OpSignedMul   = 2'd1;
  localparam logic [1:0] OpUnsignedDiv = 2'd2;
  localparam logic [1:0] OpUnsignedMul = 2'd3;

  localparam logic [1:0] StateIdle = 2'd0;
  localparam logic [1:0] StateRun  = 2'd1;
  localparam logic [1:0] StateDone = 2'd2;

  function automatic logic opIsMul(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic opIsSigned(input logic [1:0] op);
    return !op[1];
  endfunction

endpackage

// File: rtl/iterative_muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring-divide step.
// Zero latency; no handshake.
module muldiv_step #(
  parameter int L = 16
) (
  input  logic         isDiv,
  input  logic [L-1:0] acc,
  input  logic [L-1:0] operand,
  input  logic [L-1:0] part,
  output logic [L-1:0] accNext,
  output logic [L-1:0] partNext
);

  logic [L:0]   sum;
  logic [L:0]   shifted;
  logic [L-1:0] diff;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, operand};
    shifted  = {acc, part[L-1]};
    // acc < operand always holds, so the true difference fits in L bits
    diff     = shifted[L-1:0] - operand;
    accNext  = acc;
    partNext = part;
    if (isDiv) begin
      if (shifted >= {1'b0, operand}) begin
        accNext  = diff;
        partNext = {part[L-2:0], 1'b1};
      end else begin
        accNext  = shifted[L-1:0];
        partNext = {part[L-2:0], 1'b0};
      end
    end else if (part[0]) begin
      accNext  = sum[L:1];
      partNext = {sum[0], part[L-1:1]};
    end else begin
      accNext  = {1'b0, acc[L-1:1]};
      partNext = {acc[0], part[L-1:1]};
    end
  end

endmodule

// File: rtl/iterative_muldiv.sv
// Iterative signed/unsigned multiply and divide, one bit per cycle; result valid L+1
// cycles after accept (1 for divide by zero). One request in flight; DONE holds until OutReady.
module iterative_muldiv
  import iterative_muldiv_pkg::*;
#(
  parameter int L = 16
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic [1:0]   Operation,
  input  logic [L-1:0] A,
  input  logic [L-1:0] B,
  input  logic [L-1:0] FlagsIn,
  input  logic         InValid,
  output logic         InReady,
  output logic         OutValid,
  input  logic         OutReady,
  input  logic         Flush,
  output logic [L-1:0] R,
  output logic [L-1:0] R2,
  output logic [L-1:0] FlagsOut
);

  localparam int CW = $clog2(L + 1);

  logic [1:0]   state;
  logic [CW-1:0] cnt;
  logic [1:0]   opReg;
  logic [L-1:0] acc, opB, part, flagsLat;
  logic         negRes, negRem;
  logic [L-1:0] accNext, partNext;

  muldiv_step #(.L(L)) uStep (
    .isDiv   (!opIsMul(opReg)),
    .acc     (acc),
    .operand (opB),
    .part    (part),
    .accNext (accNext),
    .partNext(partNext)
  );

  // Request-side decode
  logic         inSigned, divZero;
  logic [L-1:0] aAbs, bAbs, zeroFlags;

  always_comb begin
    inSigned  = opIsSigned(Operation);
    aAbs      = (inSigned && A[L-1]) ? -A : A;
    bAbs      = (inSigned && B[L-1]) ? -B : B;
    divZero   = !opIsMul(Operation) && (B == '0);
    zeroFlags = FlagsIn;
    zeroFlags[DivisionHasRemainderIdx] = 1'b0;
    zeroFlags[DivisionByZeroIdx]       = 1'b1;
  end

  // Final result, valid on the last RUN cycle
  logic [2*L-1:0] prod, prodS;
  logic           mulOvf;
  logic [L-1:0]   resR, resR2, resFlags;

  always_comb begin
    prod     = {accNext, partNext};
    prodS    = negRes ? -prod : prod;
    mulOvf   = opIsSigned(opReg) ? !((&prodS[2*L-1:L-1]) || !(|prodS[2*L-1:L-1]))
                                 : (|prod[2*L-1:L]);
    resFlags = flagsLat;
    if (opIsMul(opReg)) begin
      resR  = prodS[L-1:0];
      resR2 = prodS[2*L-1:L];
      resFlags[MultiplicationOverflowIdx] = mulOvf;
    end else begin
      resR  = negRes ? -partNext : partNext;
      resR2 = negRem ? -accNext : accNext;
      resFlags[DivisionHasRemainderIdx] = |accNext;
      resFlags[DivisionByZeroIdx]       = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state    <= StateIdle;
      cnt      <= '0;
      opReg    <= '0;
      acc      <= '0;
      opB      <= '0;
      part     <= '0;
      flagsLat <= '0;
      negRes   <= 1'b0;
      negRem   <= 1'b0;
      R        <= '0;
      R2       <= '0;
      FlagsOut <= '0;
    end else if (Flush) begin
      state <= StateIdle;
      cnt   <= '0;
    end else begin
      case (state)
        StateIdle: begin
          if (InValid) begin
            opReg    <= Operation;
            flagsLat <= FlagsIn;
            negRes   <= inSigned && (A[L-1] ^ B[L-1]);
            negRem   <= inSigned && !opIsMul(Operation) && A[L-1];
            acc      <= '0;
            part     <= aAbs;
            opB      <= bAbs;
            if (divZero) begin
              state    <= StateDone;
              R        <= '0;
              R2       <= A;
              FlagsOut <= zeroFlags;
            end else begin
              state <= StateRun;
              cnt   <= CW'(L);
            end
          end
        end
        StateRun: begin
          acc  <= accNext;
          part <= partNext;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state    <= StateDone;
            R        <= resR;
            R2       <= resR2;
            FlagsOut <= resFlags;
          end
        end
        StateDone: begin
          if (OutReady) state <= StateIdle;
        end
        default: state <= StateIdle;
      endcase
    end
  end

  assign InReady  = (state == StateIdle);
  assign OutValid = (state == StateDone);

endmodule

// File: tb/tb_iterative_muldiv.sv
// Directed + random bench for iterative_muldiv (L=16) with an expected-result queue.
module tb_iterative_muldiv;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic [1:0]  Operation;
  logic [15:0] A, B, FlagsIn;
  logic        InValid, InReady, OutValid, OutReady, Flush;
  logic [15:0] R, R2, FlagsOut;

  iterative_muldiv #(.L(16)) dut (
    .Clk(Clk), .ResetN(ResetN), .Operation(Operation), .A(A), .B(B),
    .FlagsIn(FlagsIn), .InValid(InValid), .InReady(InReady),
    .OutValid(OutValid), .OutReady(OutReady), .Flush(Flush),
    .R(R), .R2(R2), .FlagsOut(FlagsOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] r;
    logic [15:0] r2;
    logic [15:0] f;
    int          lat;
  } expT;

  expT sb[$];
  int  nTests = 0;
  int  nFail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference built on native integer arithmetic
  task automatic model(input logic [1:0] op, input logic [15:0] a, b, f,
                       output logic [15:0] r, r2, fo, output int lat);
    logic signed [15:0] sa, sb16;
    longint ia, ib, p;
    sa = a; sb16 = b;
    fo = f; lat = 17;
    if (op[1]) begin ia = longint'(a); ib = longint'(b); end
    else begin ia = longint'(sa); ib = longint'(sb16); end
    if (op[0]) begin
      p  = ia * ib;
      r  = p[15:0];
      r2 = p[31:16];
      fo[2] = op[1] ? (p[31:16] != 16'h0) : (p > 32767 || p < -32768);
    end else if (b == 16'h0) begin
      r = 16'h0; r2 = a; fo[0] = 1'b0; fo[1] = 1'b1; lat = 1;
    end else begin
      p  = ia / ib;
      r  = p[15:0];
      p  = ia % ib;
      r2 = p[15:0];
      fo[0] = (r2 != 16'h0); fo[1] = 1'b0;
    end
  endtask

  task automatic runOp(input logic [1:0] op, input logic [15:0] a, b, f,
                       input logic [15:0] er, er2, ef, input int elat, input int hold);
    expT e, got;
    int  guard, lat;
    logic [15:0] rHold;
    e.r = er; e.r2 = er2; e.f = ef; e.lat = elat;
    sb.push_back(e);
    @(negedge Clk);
    Operation = op; A = a; B = b; FlagsIn = f; InValid = 1'b1;
    guard = 0;
    while (!InReady && guard < 50) begin @(negedge Clk); guard++; end
    check("accept_ready", {31'b0, InReady}, 32'd1);
    @(posedge Clk);
    #1 InValid = 1'b0; A = ~a; B = ~b; FlagsIn = ~f; Operation = ~op;
    lat = 0;
    while (lat < 60) begin
      @(negedge Clk);
      lat++;
      if (OutValid) break;
    end
    got = sb.pop_front();
    check("latency", lat, got.lat);
    check("R", {16'b0, R}, {16'b0, got.r});
    check("R2", {16'b0, R2}, {16'b0, got.r2});
    check("FlagsOut", {16'b0, FlagsOut}, {16'b0, got.f});
    rHold = R;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      check("hold_valid", {31'b0, OutValid}, 32'd1);
      check("hold_inready", {31'b0, InReady}, 32'd0);
      check("hold_R", {16'b0, R}, {16'b0, rHold});
    end
    @(negedge Clk);
    OutReady = 1'b1;
    @(posedge Clk);
    #1 OutReady = 1'b0;
    @(negedge Clk);
    check("release_valid", {31'b0, OutValid}, 32'd0);
    check("release_inready", {31'b0, InReady}, 32'd1);
  endtask

  task automatic runModel(input logic [1:0] op, input logic [15:0] a, b, f);
    logic [15:0] r, r2, fo;
    int lat;
    model(op, a, b, f, r, r2, fo, lat);
    runOp(op, a, b, f, r, r2, fo, lat, 0);
  endtask

  logic [15:0] rBefore;
  int          seen;

  initial begin
    ResetN = 1'b0; Operation = 2'd0; A = '0; B = '0; FlagsIn = '0;
    InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0;
    #1;
    check("rst_R", {16'b0, R}, 32'd0);
    check("rst_R2", {16'b0, R2}, 32'd0);
    check("rst_Flags", {16'b0, FlagsOut}, 32'd0);
    check("rst_OutValid", {31'b0, OutValid}, 32'd0);
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
    check("rst_InReady", {31'b0, InReady}, 32'd1);

    runOp(2'd1, 16'h0007, 16'hFFFD, 16'h0000, 16'hFFEB, 16'hFFFF, 16'h0000, 17, 0);
    runOp(2'd0, 16'hFFF9, 16'h0002, 16'h0000, 16'hFFFD, 16'hFFFF, 16'h0001, 17, 0);
    runOp(2'd0, 16'h0005, 16'h0000, 16'h0004, 16'h0000, 16'h0005, 16'h0006, 1, 0);
    runOp(2'd3, 16'h0100, 16'h0100, 16'hFFF8, 16'h0000, 16'h0001, 16'hFFFC, 17, 5);
    runOp(2'd0, 16'h8000, 16'hFFFF, 16'h0003, 16'h8000, 16'h0000, 16'h0000, 17, 0);
    runOp(2'd2, 16'hABCD, 16'h0000, 16'hFFFF, 16'h0000, 16'hABCD, 16'hFFFE, 1, 0);
    runOp(2'd1, 16'h0100, 16'h0080, 16'h0003, 16'h8000, 16'h0000, 16'h0007, 17, 0);
    runOp(2'd1, 16'hFF00, 16'h0080, 16'h0000, 16'h8000, 16'hFFFF, 16'h0000, 17, 0);
    runOp(2'd1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 17, 0);
    runOp(2'd0, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 17, 0);
    runOp(2'd2, 16'hFFFF, 16'h0010, 16'h0000, 16'h0FFF, 16'h000F, 16'h0001, 17, 0);

    for (int i = 0; i < 16; i++)
      runModel(2'($urandom_range(3)), 16'($urandom), 16'($urandom), 16'($urandom));

    // Flush at RUN cycle 4 with a competing request
    rBefore = R;
    @(negedge Clk);
    Operation = 2'd3; A = 16'h1234; B = 16'h0042; FlagsIn = 16'h0; InValid = 1'b1;
    @(posedge Clk);
    #1 InValid = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Flush = 1'b1; InValid = 1'b1; Operation = 2'd1; A = 16'h0003; B = 16'h0003;
    @(posedge Clk);
    #1 Flush = 1'b0; InValid = 1'b0;
    @(negedge Clk);
    check("flush_valid", {31'b0, OutValid}, 32'd0);
    check("flush_inready", {31'b0, InReady}, 32'd1);
    check("flush_R", {16'b0, R}, {16'b0, rBefore});
    seen = 0;
    repeat (20) begin @(negedge Clk); if (OutValid) seen++; end
    check("flush_no_valid", seen, 32'd0);
    runModel(2'd1, 16'hFF85, 16'h0033, 16'h0000);

    // Reset at RUN cycle 8
    @(negedge Clk);
    Operation = 2'd0; A = 16'h7FFF; B = 16'h0003; FlagsIn = 16'hFFFF; InValid = 1'b1;
    @(posedge Clk);
    #1 InValid = 1'b0;
    repeat (7) @(posedge Clk);
    #1 ResetN = 1'b0;
    #1;
    check("mrst_R", {16'b0, R}, 32'd0);
    check("mrst_R2", {16'b0, R2}, 32'd0);
    check("mrst_Flags", {16'b0, FlagsOut}, 32'd0);
    check("mrst_OutValid", {31'b0, OutValid}, 32'd0);
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
    check("mrst_InReady", {31'b0, InReady}, 32'd1);
    seen = 0;
    repeat (25) begin @(negedge Clk); if (OutValid) seen++; end
    check("mrst_no_valid", seen, 32'd0);
    runModel(2'd2, 16'h9C40, 16'h0007, 16'h0010);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
